// File: rtl/ariane_pkg.sv
// Shared types for the SV32 shared-TLB miss sequencer: controller states and the
// latched request record.
package ariane_pkg;

   // The request record carries a fixed-width ASID slot; the controller
   // zero-extends into it and truncates back out to its own ASID_WIDTH.
   localparam int unsigned SHARED_TLB_ASID_MAX = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_CHECK,
      ST_WAIT_PTW,
      ST_DONE,
      ST_FLUSH
   } shared_tlb_ctrl_state_e;

   typedef struct packed {
      logic [31:0]                    vaddr;
      logic [SHARED_TLB_ASID_MAX-1:0] asid;
      logic                           is_itlb;
   } shared_tlb_req_t;

endpackage

// File: rtl/shared_tlb_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is the ITLB side, bit 1 the DTLB side.
// The pointer only moves when both sides competed for the granted slot.
module shared_tlb_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic rr_ptr_reg;

   always_comb begin
      gnt = req;
      if (&req) begin
         gnt = rr_ptr_reg ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_reg <= 1'b0;
      end else if (advance && (&req)) begin
         rr_ptr_reg <= ~rr_ptr_reg;
      end
   end

endmodule

// File: rtl/cva6_shared_tlb_miss_ctrl_sv32.sv
// Sequences ITLB/DTLB misses through one shared-TLB lookup and, on a shared miss,
// a page-table walk; SFENCE.VMA flushes abort the walk and stall new grants.
module cva6_shared_tlb_miss_ctrl_sv32
   import ariane_pkg::*;
#(
   parameter int unsigned ASID_WIDTH   = 1,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned PTW_TIMEOUT  = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  enable_translation_i,
   input  logic                  en_ld_st_translation_i,
   input  logic [ASID_WIDTH-1:0] asid_i,
   input  logic                  itlb_miss_i,
   input  logic [31:0]           itlb_vaddr_i,
   input  logic                  dtlb_miss_i,
   input  logic [31:0]           dtlb_vaddr_i,
   output logic                  lookup_valid_o,
   output logic                  lookup_is_itlb_o,
   output logic [31:0]           lookup_vaddr_o,
   output logic [ASID_WIDTH-1:0] lookup_asid_o,
   input  logic                  shared_tlb_hit_i,
   output logic                  ptw_req_o,
   output logic                  ptw_is_itlb_o,
   output logic [31:0]           ptw_vaddr_o,
   output logic                  ptw_kill_o,
   input  logic                  ptw_update_valid_i,
   input  logic                  ptw_error_i,
   output logic                  busy_o,
   output logic                  itlb_done_o,
   output logic                  dtlb_done_o,
   output logic                  shared_hit_o,
   output logic                  ptw_walk_o,
   output logic                  timeout_o
);

   // One counter serves both the walk timeout and the flush countdown; the two
   // uses never overlap in time.
   localparam int unsigned CNT_MAX = (PTW_TIMEOUT > FLUSH_CYCLES) ? PTW_TIMEOUT : FLUSH_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PTW_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD   = CNT_W'(FLUSH_CYCLES - 1);

   shared_tlb_ctrl_state_e state_reg;
   shared_tlb_req_t        req_reg;
   logic [CNT_W-1:0]       cnt_reg;
   logic                   shared_hit_reg;
   logic                   ptw_walk_reg;

   logic [1:0] eligible;
   logic [1:0] arb_gnt;
   logic       grant;
   logic       ptw_resp;
   logic       timeout_hit;

   assign eligible    = {dtlb_miss_i & en_ld_st_translation_i, itlb_miss_i & enable_translation_i};
   assign grant       = (state_reg == ST_IDLE) && !flush_i && (|eligible);
   assign ptw_resp    = ptw_update_valid_i | ptw_error_i;
   assign timeout_hit = (state_reg == ST_WAIT_PTW) && (cnt_reg == TIMEOUT_LAST) && !ptw_resp;

   shared_tlb_rr_arb2 u_arb (
      .clk     (clk_i),
      .rst     (rst_i),
      .req     (eligible),
      .advance (grant),
      .gnt     (arb_gnt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg      <= ST_IDLE;
         req_reg        <= '0;
         cnt_reg        <= '0;
         shared_hit_reg <= 1'b0;
         ptw_walk_reg   <= 1'b0;
      end else begin
         shared_hit_reg <= 1'b0;
         ptw_walk_reg   <= 1'b0;
         if (flush_i) begin
            // Any in-flight request is dropped; a flush during FLUSH restarts the countdown.
            state_reg <= ST_FLUSH;
            cnt_reg   <= FLUSH_LOAD;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (grant) begin
                     req_reg.vaddr   <= arb_gnt[0] ? itlb_vaddr_i : dtlb_vaddr_i;
                     req_reg.is_itlb <= arb_gnt[0];
                     req_reg.asid    <= SHARED_TLB_ASID_MAX'(asid_i);
                     state_reg       <= ST_LOOKUP;
                  end
               end
               ST_LOOKUP: state_reg <= ST_CHECK;
               ST_CHECK: begin
                  if (shared_tlb_hit_i) begin
                     shared_hit_reg <= 1'b1;
                     state_reg      <= ST_DONE;
                  end else begin
                     ptw_walk_reg <= 1'b1;
                     cnt_reg      <= '0;
                     state_reg    <= ST_WAIT_PTW;
                  end
               end
               ST_WAIT_PTW: begin
                  if (ptw_resp || (cnt_reg == TIMEOUT_LAST)) begin
                     state_reg <= ST_DONE;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
               ST_DONE: state_reg <= ST_IDLE;
               ST_FLUSH: begin
                  if (cnt_reg == '0) begin
                     state_reg <= ST_IDLE;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy_o           = (state_reg != ST_IDLE);
   assign lookup_valid_o   = (state_reg == ST_LOOKUP);
   assign lookup_is_itlb_o = req_reg.is_itlb;
   assign lookup_vaddr_o   = req_reg.vaddr;
   assign lookup_asid_o    = ASID_WIDTH'(req_reg.asid);
   assign ptw_is_itlb_o    = req_reg.is_itlb;
   assign ptw_vaddr_o      = req_reg.vaddr;

   // Walk start and kill react to flush/reset in the same cycle so a dropped
   // request never launches or leaves a walk running.
   assign ptw_req_o   = (state_reg == ST_CHECK) && !shared_tlb_hit_i && !flush_i && !rst_i;
   assign ptw_kill_o  = (state_reg == ST_WAIT_PTW) && (flush_i || timeout_hit) && !rst_i;
   assign timeout_o   = timeout_hit && !flush_i && !rst_i;

   assign itlb_done_o  = (state_reg == ST_DONE) && req_reg.is_itlb;
   assign dtlb_done_o  = (state_reg == ST_DONE) && !req_reg.is_itlb;
   assign shared_hit_o = shared_hit_reg;
   assign ptw_walk_o   = ptw_walk_reg;

endmodule
